// File: rtl/pipe_mac_acc.sv
// Four-stage pipelined multiply-add-accumulate: out_sum is the running per-frame sum of a*b+c.
// Frames are delimited by in_last; overflow either saturates or wraps and is flagged per frame.
module pipe_mac_acc #(
  parameter int unsigned W      = 4,
  parameter int unsigned ACC_W  = 12,
  parameter bit          SIGNED = 1'b0,
  parameter bit          SAT    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  input  logic [W-1:0]     i_c,
  output logic             out_valid,
  output logic             out_last,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned TW = 2 * W + 1;

  if (ACC_W < TW) begin : g_acc_w_check
    $error("pipe_mac_acc: ACC_W must be at least 2*W+1");
  end

  // Stage registers
  logic [W-1:0]     a1_q, b1_q, c1_q, c2_q;
  logic             v1_q, l1_q, v2_q, l2_q, v3_q, l3_q;
  logic [PW-1:0]    mul2_q;
  logic [TW-1:0]    term3_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             first_q, first_d;
  logic             ovf_q, ovf_d;
  logic             vo_q, lo_q;

  // Combinational datapath
  logic [PW-1:0]    a_ext, b_ext, mul_d;
  logic [TW-1:0]    term_d;
  logic [ACC_W-1:0] term_ext;
  logic [ACC_W:0]   sum_w;
  logic             ovf_beat;

  always_comb begin
    a_ext  = {{W{SIGNED & a1_q[W-1]}}, a1_q};
    b_ext  = {{W{SIGNED & b1_q[W-1]}}, b1_q};
    // Low PW bits of the extended product are correct for both signed and unsigned math
    mul_d  = a_ext * b_ext;
    term_d = {SIGNED & mul2_q[PW-1], mul2_q} + {{(W + 1){SIGNED & c2_q[W-1]}}, c2_q};

    // Mask-based sign extension also covers ACC_W == TW
    term_ext = ACC_W'(term3_q);
    if (SIGNED && term3_q[TW-1]) begin
      term_ext = term_ext | ~(ACC_W'({TW{1'b1}}));
    end

    sum_w = {1'b0, acc_q} + {1'b0, term_ext};
    if (SIGNED) begin
      ovf_beat = (acc_q[ACC_W-1] == term_ext[ACC_W-1]) && (sum_w[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      ovf_beat = sum_w[ACC_W];
    end

    acc_d   = acc_q;
    ovf_d   = ovf_q;
    first_d = first_q;
    if (v3_q) begin
      first_d = l3_q;
      if (first_q) begin
        // A single term cannot overflow the accumulator, so the flag restarts clear
        acc_d = term_ext;
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q | ovf_beat;
        if (ovf_beat && SAT) begin
          if (SIGNED) begin
            acc_d = acc_q[ACC_W-1] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
          end else begin
            acc_d = {ACC_W{1'b1}};
          end
        end else begin
          acc_d = sum_w[ACC_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a1_q    <= '0;
      b1_q    <= '0;
      c1_q    <= '0;
      v1_q    <= 1'b0;
      l1_q    <= 1'b0;
      mul2_q  <= '0;
      c2_q    <= '0;
      v2_q    <= 1'b0;
      l2_q    <= 1'b0;
      term3_q <= '0;
      v3_q    <= 1'b0;
      l3_q    <= 1'b0;
      acc_q   <= '0;
      first_q <= 1'b1;
      ovf_q   <= 1'b0;
      vo_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      a1_q    <= i_a;
      b1_q    <= i_b;
      c1_q    <= i_c;
      v1_q    <= in_valid;
      l1_q    <= in_valid & in_last;
      mul2_q  <= mul_d;
      c2_q    <= c1_q;
      v2_q    <= v1_q;
      l2_q    <= l1_q;
      term3_q <= term_d;
      v3_q    <= v2_q;
      l3_q    <= l2_q;
      acc_q   <= acc_d;
      first_q <= first_d;
      ovf_q   <= ovf_d;
      vo_q    <= v3_q;
      lo_q    <= v3_q & l3_q;
    end
  end

  assign out_valid = vo_q;
  assign out_last  = lo_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipe_mac_acc.sv
// Scoreboard bench for pipe_mac_acc: four instances cover unsigned, signed, saturating and
// wrapping configurations; directed beats push hand-computed results checked by a monitor.
module tb_pipe_mac_acc;

  logic       clk;
  logic       rst;
  logic [3:0] iv;
  logic       in_last;
  logic [3:0] i_a, i_b, i_c;

  logic        ov0, ol0, oo0, ov1, ol1, oo1, ov2, ol2, oo2, ov3, ol3, oo3;
  logic [11:0] os0, os1;
  logic [8:0]  os2, os3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [11:0] sum;
    logic        last;
    logic        ovf;
    int          at;
  } exp_t;

  exp_t q0[$], q1[$], q2[$], q3[$];

  pipe_mac_acc #(.W(4), .ACC_W(12), .SIGNED(1'b0), .SAT(1'b1)) u_uns (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_last(in_last), .i_a(i_a), .i_b(i_b), .i_c(i_c),
    .out_valid(ov0), .out_last(ol0), .out_sum(os0), .out_ovf(oo0));
  pipe_mac_acc #(.W(4), .ACC_W(12), .SIGNED(1'b1), .SAT(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_last(in_last), .i_a(i_a), .i_b(i_b), .i_c(i_c),
    .out_valid(ov1), .out_last(ol1), .out_sum(os1), .out_ovf(oo1));
  pipe_mac_acc #(.W(4), .ACC_W(9), .SIGNED(1'b0), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_last(in_last), .i_a(i_a), .i_b(i_b), .i_c(i_c),
    .out_valid(ov2), .out_last(ol2), .out_sum(os2), .out_ovf(oo2));
  pipe_mac_acc #(.W(4), .ACC_W(9), .SIGNED(1'b0), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_last(in_last), .i_a(i_a), .i_b(i_b), .i_c(i_c),
    .out_valid(ov3), .out_last(ol3), .out_sum(os3), .out_ovf(oo3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic set_in(input int d, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic last);
    iv      = '0;
    iv[d]   = 1'b1;
    i_a     = a;
    i_b     = b;
    i_c     = c;
    in_last = last;
  endtask

  // A beat driven in cycle n is expected on the outputs in cycle n+4
  task automatic push(input int d, input logic [11:0] sum, input logic last, input logic ovf);
    exp_t e;
    e.sum  = sum;
    e.last = last;
    e.ovf  = ovf;
    e.at   = cyc + 4;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic beat(input int d, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      input logic last, input logic [11:0] sum, input logic elast,
                      input logic eovf);
    @(negedge clk);
    set_in(d, a, b, c, last);
    push(d, sum, elast, eovf);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      iv      = '0;
      in_last = 1'b0;
    end
  endtask

  task automatic mon(input int d, input logic [11:0] s, input logic l, input logic o);
    exp_t e;
    bit   got;
    got = 1'b0;
    case (d)
      0: if (q0.size() != 0) begin e = q0.pop_front(); got = 1'b1; end
      1: if (q1.size() != 0) begin e = q1.pop_front(); got = 1'b1; end
      2: if (q2.size() != 0) begin e = q2.pop_front(); got = 1'b1; end
      default: if (q3.size() != 0) begin e = q3.pop_front(); got = 1'b1; end
    endcase
    total++;
    if (!got) begin
      bad++;
      $display("FAIL unexpected_beat dut%0d: got sum=%0d last=%0b ovf=%0b at cycle %0d, want none",
               d, s, l, o, cyc);
    end else if (s !== e.sum || l !== e.last || o !== e.ovf || cyc != e.at) begin
      bad++;
      $display("FAIL beat dut%0d: got sum=%0d last=%0b ovf=%0b cycle=%0d want sum=%0d last=%0b ovf=%0b cycle=%0d",
               d, s, l, o, cyc, e.sum, e.last, e.ovf, e.at);
    end
  endtask

  always @(negedge clk) begin
    if (ov0) mon(0, os0, ol0, oo0);
    if (ov1) mon(1, os1, ol1, oo1);
    if (ov2) mon(2, {3'b000, os2}, ol2, oo2);
    if (ov3) mon(3, {3'b000, os3}, ol3, oo3);
  end

  initial begin
    rst     = 1'b1;
    iv      = '0;
    in_last = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_c     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_valid", {11'b0, ov0}, 12'd0);
    chk("reset_last", {11'b0, ol0}, 12'd0);
    chk("reset_sum", os0, 12'd0);
    chk("reset_ovf", {11'b0, oo0}, 12'd0);

    // Unsigned frame
    beat(0, 4'd3, 4'd5, 4'd2, 1'b0, 12'd17, 1'b0, 1'b0);
    beat(0, 4'd15, 4'd15, 4'd15, 1'b0, 12'd257, 1'b0, 1'b0);
    beat(0, 4'd1, 4'd1, 4'd0, 1'b1, 12'd258, 1'b1, 1'b0);
    idle(8);

    // Signed: (-8)*7 + (-8) = -64, then a fresh frame 7*7+7
    beat(1, 4'h8, 4'h7, 4'h8, 1'b1, 12'hFC0, 1'b1, 1'b0);
    beat(1, 4'd7, 4'd7, 4'd7, 1'b1, 12'd56, 1'b1, 1'b0);
    idle(8);

    // Saturating 9-bit accumulator; flag stays sticky through the last beat
    beat(2, 4'd15, 4'd15, 4'd15, 1'b0, 12'd240, 1'b0, 1'b0);
    beat(2, 4'd15, 4'd15, 4'd15, 1'b0, 12'd480, 1'b0, 1'b0);
    beat(2, 4'd15, 4'd15, 4'd15, 1'b0, 12'd511, 1'b0, 1'b1);
    beat(2, 4'd0, 4'd0, 4'd0, 1'b1, 12'd511, 1'b1, 1'b1);
    beat(2, 4'd1, 4'd1, 4'd0, 1'b1, 12'd1, 1'b1, 1'b0);
    idle(8);

    // Wrapping 9-bit accumulator: 720 mod 512 = 208
    beat(3, 4'd15, 4'd15, 4'd15, 1'b0, 12'd240, 1'b0, 1'b0);
    beat(3, 4'd15, 4'd15, 4'd15, 1'b0, 12'd480, 1'b0, 1'b0);
    beat(3, 4'd15, 4'd15, 4'd15, 1'b0, 12'd208, 1'b0, 1'b1);
    beat(3, 4'd0, 4'd0, 4'd0, 1'b1, 12'd208, 1'b1, 1'b1);
    beat(3, 4'd1, 4'd1, 4'd0, 1'b1, 12'd1, 1'b1, 1'b0);
    idle(8);

    // Bubbles: sum must hold between the two output beats
    beat(0, 4'd2, 4'd2, 4'd0, 1'b0, 12'd4, 1'b0, 1'b0);
    idle(2);
    beat(0, 4'd1, 4'd1, 4'd1, 1'b1, 12'd6, 1'b1, 1'b0);
    idle(2);
    chk("bubble1_valid", {11'b0, ov0}, 12'd0);
    chk("bubble1_sum", os0, 12'd4);
    idle(1);
    chk("bubble2_valid", {11'b0, ov0}, 12'd0);
    chk("bubble2_sum", os0, 12'd4);
    idle(8);

    // Back-to-back frames; the third beat leaves a frame open
    beat(0, 4'd1, 4'd1, 4'd0, 1'b1, 12'd1, 1'b1, 1'b0);
    beat(0, 4'd2, 4'd2, 4'd0, 1'b1, 12'd4, 1'b1, 1'b0);
    beat(0, 4'd3, 4'd3, 4'd0, 1'b0, 12'd9, 1'b0, 1'b0);
    idle(8);

    // Reset mid-frame; the beat coinciding with reset is dropped too
    @(negedge clk);
    set_in(0, 4'd3, 4'd3, 4'd0, 1'b0);
    @(negedge clk);
    set_in(0, 4'd3, 4'd3, 4'd0, 1'b0);
    @(negedge clk);
    set_in(0, 4'd9, 4'd9, 4'd9, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", {11'b0, ov0}, 12'd0);
    chk("midrst_last", {11'b0, ol0}, 12'd0);
    chk("midrst_sum", os0, 12'd0);
    chk("midrst_ovf", {11'b0, oo0}, 12'd0);
    set_in(0, 4'd2, 4'd3, 4'd1, 1'b1);
    push(0, 12'd7, 1'b1, 1'b0);
    idle(10);

    chk("drain_q0", 12'(q0.size()), 12'd0);
    chk("drain_q1", 12'(q1.size()), 12'd0);
    chk("drain_q2", 12'(q2.size()), 12'd0);
    chk("drain_q3", 12'(q3.size()), 12'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
